approx_pp_reducer: RTL and testbench
====================================

// Module: approx_pp_reducer
// PURPOSE
// - Downstream neighbour of the partial-product generator (gen_prod) in the 6x6 approximate multiplier.
// - Consumes the flattened NxN partial-product matrix and reduces it to a 2N-bit product.
// - Low-weight columns are compressed approximately (column OR); high-weight columns are summed exactly.
// - Two-stage registered pipeline with valid/ready handshakes at both ends; sustains full throughput.
// PARAMETERS
// - N            6   operand width; the matrix is N*N bits and the product is 2N bits
// - APPROX_COLS  3   column weights 0..APPROX_COLS-1 are approximated; legal range 0..2N-2 (0 = exact multiplier)
// - CNT_W        16  width of the accepted-result counter
// PORTS
// - clk        in   1      single clock; all state updates on the rising edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      pp_flat holds a valid matrix
// - in_ready   out  1      block can accept pp_flat this cycle
// - pp_flat    in   N*N    pp[i][j] is bit i*N+j, with weight i+j (i = x bit, j = y bit)
// - out_valid  out  1      prod is valid
// - out_ready  in   1      downstream accepts prod this cycle
// - prod       out  2N     approximate product
// - out_count  out  CNT_W  number of products handed off downstream; wraps modulo 2^CNT_W
// BEHAVIOUR
// - Arithmetic: col_k is the set of pp bits with i+j == k.
//   prod = sum_{k<APPROX_COLS} (OR(col_k) << k) + sum_{k>=APPROX_COLS} (popcount(col_k) << k), truncated to 2N bits.
//   The result is never larger than the exact product, so it never overflows 2N bits.
// - Stage 1 (S1): registers two 2N-bit operands opA and opB with opA+opB equal to the formula above.
//   The split between opA and opB is free; the sum is mandatory.
// - Stage 2 (S2): registers prod = opA + opB (2N-bit add, carry-out discarded).
// - Latency: exactly 2 cycles from the in_valid&&in_ready edge to out_valid, when there is no backpressure.
// - Each stage holds a valid bit.
//   - S2 loads whenever !s2_valid || out_ready.
//   - S1 loads whenever !s1_valid || (S2 loads).
//   - in_ready = !s1_valid || (!s2_valid || out_ready).
//   - in_ready is combinational from out_ready; no other comb path runs from inputs to outputs.
// - Stall: while out_valid && !out_ready, prod and out_valid hold stable and S2 does not load.
//   If S1 is also valid, in_ready = 0 and S1 holds. pp_flat is ignored whenever in_ready = 0.
// - Simultaneous events: with out_ready = 1, a pop from S2 and pushes into S2 and S1 all complete in the same cycle.
// - Bubbles: an empty stage forwards immediately; an invalid input never creates an output.
// - out_count increments by 1 on every cycle with out_valid && out_ready.
// - Reset (asynchronous, mid-operation included):
//   - s1_valid, s2_valid, out_valid and out_count go to 0; prod, opA and opB go to 0.
//   - In-flight data is discarded; in_ready = 1 after reset.
// - Valid bits and datapath registers are never X after reset.
// STRUCTURE
// - Shared package approx_mult_pkg holds: N, PW = 2N, default APPROX_COLS, and function approx_ref(pp_flat).
//   approx_ref implements the arithmetic formula above; RTL and bench both use it for cross-checks.
// - One sub-module: approx_col_compressor (combinational S1 logic: pp_flat -> opA, opB).
// - This module owns the handshake, the pipeline registers, the final adder and the counter.
// TESTING
// - Reset, then pp for a=1, b=3 (bits 0 and 1 set) with out_ready=1 -> out_valid 2 cycles later, prod=3.
// - a=63, b=63 (all 36 bits set), APPROX_COLS=3 -> prod=3959.
//   Exact product 3969; low columns contribute 7 instead of 17.
// - a=5, b=6 -> prod=30; every approximated column holds at most one bit, so the result equals the exact product.
// - Backpressure: stream 3 matrices with out_ready=0 ->
//   - out_valid=1 holding the first prod; in_ready drops to 0 after the second accept.
//   - Releasing out_ready delivers all 3 in order, with no loss or duplication.
// - Back-to-back: 100 random matrices, in_valid=1 and out_ready=1 every cycle ->
//   - one result per cycle, each equal to approx_ref; out_count=100.
// - Reset mid-stream: assert rst while S1 and S2 are both valid ->
//   - out_valid=0, out_count=0 and in_ready=1 immediately; no stale prod appears after release.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared constants and reference arithmetic for the 6x6 approximate multiplier.
// approx_ref gives the golden product for a flattened partial-product matrix.
package approx_mult_pkg;

    localparam int N               = 6;
    localparam int PW              = 2 * N;
    localparam int APPROX_COLS_DEF = 3;

    // Low columns contribute OR(col) at their weight, high columns popcount(col).
    function automatic logic [PW-1:0] approx_ref(
        input logic [N*N-1:0] pp,
        input int             approx_cols = APPROX_COLS_DEF
    );
        int acc;
        int cnt;
        acc = 0;
        for (int k = 0; k < PW - 1; k++) begin
            cnt = 0;
            for (int idx = 0; idx < N * N; idx++) begin
                if ((idx / N) + (idx % N) == k) begin
                    cnt += int'(pp[idx]);
                end
            end
            if (k < approx_cols) begin
                cnt = (cnt != 0) ? 1 : 0;
            end
            acc += cnt << k;
        end
        return acc[PW-1:0];
    endfunction

endpackage

// File: rtl/approx_col_compressor.sv
// Stage-1 combinational reduction of the partial-product matrix.
// op_a carries the OR of each approximated column, op_b the weighted exact popcounts.
module approx_col_compressor
    import approx_mult_pkg::*;
#(
    parameter int APPROX_COLS = APPROX_COLS_DEF
) (
    input  logic [N*N-1:0] pp_flat_i,
    output logic [PW-1:0]  op_a_o,
    output logic [PW-1:0]  op_b_o
);

    logic          col_or;
    logic [PW-1:0] col_cnt;

    // Walk columns by weight; approximated bits never overlap so op_a needs no adder.
    always_comb begin
        op_a_o  = '0;
        op_b_o  = '0;
        col_or  = 1'b0;
        col_cnt = '0;
        for (int k = 0; k < PW - 1; k++) begin
            col_or  = 1'b0;
            col_cnt = '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i + j == k) begin
                        col_or  = col_or | pp_flat_i[i*N+j];
                        col_cnt = col_cnt + PW'(pp_flat_i[i*N+j]);
                    end
                end
            end
            if (k < APPROX_COLS) begin
                op_a_o[k] = col_or;
            end else begin
                op_b_o = op_b_o + (col_cnt << k);
            end
        end
    end

endmodule

// File: rtl/approx_pp_reducer.sv
// Two-stage partial-product reducer: S1 compresses columns, S2 adds the two operands.
// Both stages use valid bits with a ready chain so the pipe streams at one result per cycle.
module approx_pp_reducer
    import approx_mult_pkg::*;
#(
    parameter int APPROX_COLS = APPROX_COLS_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N-1:0]   pp_flat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    prod,
    output logic [CNT_W-1:0] out_count
);

    logic             s1_valid_q;
    logic             s2_valid_q;
    logic [PW-1:0]    op_a_q;
    logic [PW-1:0]    op_b_q;
    logic [PW-1:0]    op_a_d;
    logic [PW-1:0]    op_b_d;
    logic [PW-1:0]    prod_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s1_load;
    logic             s2_load;

    approx_col_compressor #(
        .APPROX_COLS(APPROX_COLS)
    ) u_comp (
        .pp_flat_i(pp_flat),
        .op_a_o   (op_a_d),
        .op_b_o   (op_b_d)
    );

    assign s2_load   = !s2_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign prod      = prod_q;
    assign out_count = cnt_q;

    // S1: capture compressed operands whenever the stage is free to move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                op_a_q <= op_a_d;
                op_b_q <= op_b_d;
            end
        end
    end

    // S2: final add; holds the product while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                prod_q <= op_a_q + op_b_q;
            end
        end
    end

    // Count products handed off downstream; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (s2_valid_q && out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_approx_pp_reducer.sv
// Randomised self-checking bench for approx_pp_reducer.
// Expected products come from a column-sum model built from the arithmetic rule.
module tb_approx_pp_reducer;
    import approx_mult_pkg::*;

    localparam int AC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [35:0]   pp_flat;
    logic          out_valid;
    logic          out_ready;
    logic [11:0]   prod;
    logic [15:0]   out_count;

    int checks = 0;
    int errors = 0;

    approx_pp_reducer #(.APPROX_COLS(AC), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pp_flat  (pp_flat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .prod     (prod),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    // Column tally: each set bit lands in column i+j; low columns saturate at 1.
    function automatic int model(input logic [35:0] pp);
        int col [11];
        int s;
        foreach (col[k]) col[k] = 0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                if (pp[i*6+j]) col[i+j]++;
        s = 0;
        foreach (col[k]) s += ((k < AC && col[k] > 1) ? 1 : col[k]) * (1 << k);
        return s % 4096;
    endfunction

    function automatic logic [35:0] mk_pp(input int a, input int b);
        logic [35:0] pp;
        pp = '0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                pp[i*6+j] = a[i] & b[j];
        return pp;
    endfunction

    function automatic logic [35:0] rnd_pp();
        logic [35:0] pp;
        pp[31:0]  = $urandom;
        pp[35:32] = 4'($urandom);
        return pp;
    endfunction

    // One cycle: drive at negedge, observe before the next rising edge.
    task automatic cycle(input logic v, input logic [35:0] pp, input logic ordy,
                         output logic acc, output logic pop,
                         output logic ov, output logic ir, output logic [11:0] p);
        @(negedge clk);
        in_valid  = v;
        pp_flat   = pp;
        out_ready = ordy;
        #1;
        ir  = in_ready;
        ov  = out_valid;
        acc = v && in_ready;
        pop = out_valid && ordy;
        p   = prod;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pp_flat = '0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 16'd0 || prod !== 12'd0) begin
            errors++;
            $display("FAIL reset: ov=%b ir=%b cnt=%0d prod=%0d want 0 1 0 0",
                     out_valid, in_ready, out_count, prod);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single(input int a, input int b, input int exp);
        logic acc, pop, ov, ir;
        logic [11:0] p;
        logic [35:0] pp;
        pp = mk_pp(a, b);
        checks++;
        if (model(pp) != exp || approx_ref(pp, AC) !== 12'(exp)) begin
            errors++;
            $display("FAIL ref_%0dx%0d: model=%0d pkg=%0d want %0d", a, b, model(pp), approx_ref(pp, AC), exp);
        end
        cycle(1'b1, pp, 1'b1, acc, pop, ov, ir, p);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL accept_%0dx%0d: got %b want 1", a, b, acc);
        end
        cycle(1'b0, '0, 1'b1, acc, pop, ov, ir, p);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL early_valid_%0dx%0d: got %b want 0", a, b, ov);
        end
        cycle(1'b0, '0, 1'b1, acc, pop, ov, ir, p);
        checks++;
        if (ov !== 1'b1 || p !== 12'(exp)) begin
            errors++;
            $display("FAIL prod_%0dx%0d: valid=%b prod=%0d want 1 %0d", a, b, ov, p, exp);
        end
        cycle(1'b0, '0, 1'b1, acc, pop, ov, ir, p);
    endtask

    task automatic test_pkg_ref();
        logic [35:0] pp;
        for (int n = 0; n < 20; n++) begin
            pp = rnd_pp();
            checks++;
            if (approx_ref(pp, AC) !== 12'(model(pp))) begin
                errors++;
                $display("FAIL pkg_ref: got %0d want %0d", approx_ref(pp, AC), model(pp));
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc, pop, ov, ir;
        logic [11:0] p;
        logic [35:0] m [3];
        int exp_q [$];
        int sent = 0, got = 0, cyc = 0;
        foreach (m[k]) m[k] = rnd_pp();
        while (got < 3 && cyc < 20) begin
            cycle(sent < 3, (sent < 3) ? m[sent] : 36'd0, cyc >= 4, acc, pop, ov, ir, p);
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (ir !== 1'b0 || ov !== 1'b1 || p !== 12'(model(m[0]))) begin
                    errors++;
                    $display("FAIL stall_c%0d: ir=%b ov=%b prod=%0d want 0 1 %0d",
                             cyc, ir, ov, p, model(m[0]));
                end
            end
            if (pop) begin
                checks++;
                if (exp_q.size() == 0 || p !== 12'(exp_q[0])) begin
                    errors++;
                    $display("FAIL bp_order: got %0d want %0d", p,
                             exp_q.size() ? exp_q[0] : -1);
                end
                if (exp_q.size()) void'(exp_q.pop_front());
                got++;
            end
            if (acc) begin
                exp_q.push_back(model(m[sent]));
                sent++;
            end
            cyc++;
        end
        cycle(1'b0, '0, 1'b1, acc, pop, ov, ir, p);
        checks++;
        if (got != 3 || sent != 3 || ov !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: got=%0d sent=%0d ov=%b want 3 3 0", got, sent, ov);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, pop, ov, ir;
        logic [11:0] p;
        logic [35:0] pp;
        int exp_q [$];
        int sent = 0, got = 0, cyc = 0, bad = 0;
        do_reset();
        while (got < 100 && cyc < 200) begin
            pp = rnd_pp();
            cycle(sent < 100, pp, 1'b1, acc, pop, ov, ir, p);
            if (pop) begin
                if (exp_q.size() == 0 || p !== 12'(exp_q[0])) begin
                    bad++;
                    $display("FAIL b2b_data: got %0d want %0d", p,
                             exp_q.size() ? exp_q[0] : -1);
                end
                if (exp_q.size()) void'(exp_q.pop_front());
                got++;
            end
            if (acc) begin
                exp_q.push_back(model(pp));
                sent++;
            end
            cyc++;
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (got != 100 || cyc != 102) begin
            errors++;
            $display("FAIL b2b_rate: results=%0d cycles=%0d want 100 102", got, cyc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_count !== 16'd100) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 100", out_count);
        end
    endtask

    task automatic test_reset_midstream();
        logic acc, pop, ov, ir;
        logic [11:0] p;
        int seen = 0;
        cycle(1'b1, rnd_pp(), 1'b0, acc, pop, ov, ir, p);
        cycle(1'b1, rnd_pp(), 1'b0, acc, pop, ov, ir, p);
        cycle(1'b0, '0, 1'b0, acc, pop, ov, ir, p);
        checks++;
        if (ov !== 1'b1 || ir !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: ov=%b ir=%b want 1 0", ov, ir);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd0 || in_ready !== 1'b1 || prod !== 12'd0) begin
            errors++;
            $display("FAIL mid_reset: ov=%b cnt=%0d ir=%b prod=%0d want 0 0 1 0",
                     out_valid, out_count, in_ready, prod);
        end
        #2 rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cycle(1'b0, '0, 1'b1, acc, pop, ov, ir, p);
            if (ov) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_stale: got %0d stale outputs want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single(1, 3, 3);
        test_single(63, 63, 3959);
        test_single(5, 6, 30);
        test_pkg_ref();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
